// File: rtl/svc_soc_run_ctrl.sv
// Run lifecycle sequencer: CPU reset hold, run counters, halt/trap/watchdog end, optional UART drain.
// Define SVC_RUN_CTRL_DRAIN_EN to wait for the UART to go idle before reporting done.
module svc_soc_run_ctrl #(
    parameter longint unsigned WATCHDOG_CYCLES = 64'd100_000_000,
    parameter int unsigned     RST_HOLD_CYCLES = 8,
    parameter int unsigned     CNT_W           = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             retired,
    input  logic             halt_req,
    input  logic [7:0]       halt_code,
    input  logic             trap,
    input  logic             uart_tx_busy,
    output logic             cpu_rst,
    output logic             running,
    output logic             done,
    output logic [1:0]       cause,
    output logic [7:0]       exit_code,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned      HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(WATCHDOG_CYCLES - 64'd1);
    localparam bit                WD_EN     = (WATCHDOG_CYCLES != 64'd0);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  cycles_next;
    logic [CNT_W-1:0]  instret_next;
    logic              wd_hit;
    logic              term;
    logic [1:0]        term_cause;

    // Saturating counters and the same-cycle end-of-run priority (trap > halt > timeout).
    always_comb begin
        cycles_next  = (cycles == CNT_MAX) ? cycles : cycles + 1'b1;
        instret_next = (retired && instret != CNT_MAX) ? instret + 1'b1 : instret;
        wd_hit       = WD_EN && (cycles == WD_LAST);
        term         = trap || halt_req || wd_hit;
        if (trap)
            term_cause = 2'd2;
        else if (halt_req)
            term_cause = 2'd1;
        else
            term_cause = 2'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            cpu_rst   <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            cause     <= 2'd0;
            exit_code <= 8'd0;
            cycles    <= '0;
            instret   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= HOLD;
                        hold_cnt  <= '0;
                        done      <= 1'b0;
                        cause     <= 2'd0;
                        exit_code <= 8'd0;
                        cycles    <= '0;
                        instret   <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                        running <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    cycles  <= cycles_next;
                    instret <= instret_next;
                    if (term) begin
                        cause     <= term_cause;
                        exit_code <= (term_cause == 2'd1) ? halt_code : 8'd0;
                        running   <= 1'b0;
                        cpu_rst   <= 1'b1;
`ifdef SVC_RUN_CTRL_DRAIN_EN
                        state     <= DRAIN;
`else
                        state     <= DONE;
                        done      <= 1'b1;
`endif
                    end
                end
                // Only reachable when draining is enabled.
                DRAIN: begin
                    if (!uart_tx_busy) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cpu_rst <= 1'b1;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
